qoi_pixel_framer: RTL
=====================

Name: qoi_pixel_framer

Overview:
- Sits between the QOI pixel decoder and the AXI-stream pixel sink that writes PPM files.
- Latches the image header (width, height) and accepts decoded RGB pixels through a valid/ready pair.
- Buffers pixels in a small FIFO and tags each one with end-of-image (tlast) from column/row counters.
- Presents an AXI-stream master with width/height held stable for the whole frame, so the sink can emit a correct PPM header.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (legal range 1..8).

Ports:
- clk        input   1   clock; all logic on posedge
- rstn       input   1   asynchronous active-low reset
- i_hdr_en   input   1   header strobe; i_width/i_height valid this cycle
- i_width    input   32  image width in pixels
- i_height   input   32  image height in pixels
- o_hdr_rdy  output  1   1 while in IDLE; a header is accepted only when i_hdr_en & o_hdr_rdy
- i_pix_en   input   1   decoded pixel valid
- i_R        input   8   red
- i_G        input   8   green
- i_B        input   8   blue
- o_pix_rdy  output  1   1 when in STREAM and FIFO not full
- o_tvalid   output  1   AXI-stream valid (FIFO not empty)
- i_tready   input   1   AXI-stream ready from sink
- o_tlast    output  1   last pixel of image, qualified by o_tvalid
- o_R        output  8   head pixel red
- o_G        output  8   head pixel green
- o_B        output  8   head pixel blue
- o_width    output  32  latched width, stable from header accept until frame done
- o_height   output  32  latched height, stable from header accept until frame done
- o_frame_done output 1  1-cycle pulse when the tlast beat handshakes (o_tvalid & i_tready & o_tlast)
- o_overflow output  1   sticky; set on any i_pix_en while o_pix_rdy=0

Behaviour:
- Reset (rstn=0, asynchronous):
  - State IDLE; FIFO pointers and counters cleared.
  - Outputs: o_tvalid=0, o_tlast=0, o_R/o_G/o_B=0, o_width=0, o_height=0, o_frame_done=0, o_overflow=0, o_pix_rdy=0, o_hdr_rdy=1.
  - Reset mid-frame discards all buffered pixels. Outputs are at reset values while rstn=0.
- State machine IDLE -> STREAM -> DRAIN -> IDLE:
  - IDLE: o_hdr_rdy=1. On header accept, latch width/height and clear x=0, y=0.
    - If width==0 or height==0: stay in IDLE; no pixels, no frame_done.
    - Otherwise go to STREAM.
  - STREAM: each accepted pixel (i_pix_en & o_pix_rdy) is pushed with tag last=(x==W-1 && y==H-1).
    - x increments; when x==W-1 it wraps to 0 and y increments.
    - Pushing the last-tagged pixel moves the state to DRAIN.
  - DRAIN: no pixels accepted (o_pix_rdy=0). Return to IDLE in the cycle after the tlast beat handshakes; o_frame_done pulses on that handshake cycle.
  - i_hdr_en outside IDLE is ignored: no latch, no error.
- FIFO behaviour:
  - First-word-fall-through. o_tvalid = !empty. o_R/o_G/o_B/o_tlast show the head entry.
  - Data is stable while o_tvalid & !i_tready (AXI rule).
  - Latency: a pixel accepted at edge N is visible on o_tvalid after edge N. Minimum pixel-in to beat-out is 1 cycle.
  - o_pix_rdy is registered or derived only from state and the full flag. There is no combinational path from i_tready to o_pix_rdy.
  - When full, o_pix_rdy=0 even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full or not empty: occupancy is unchanged and both take effect.
  - Pointers wrap modulo 2**DEPTH_LOG2. Full/empty use an extra pointer bit.
  - When empty, o_R/o_G/o_B/o_tlast are don't-care; o_tvalid=0.
- Width rules:
  - Counters x and y are 32-bit; compares use W-1 and H-1 in 32-bit unsigned.
  - Width 1 means every pixel wraps x; height 1 means tlast falls on pixel W-1.
- o_overflow: set when i_pix_en=1 and o_pix_rdy=0, in any state. The pixel is dropped. Cleared only by reset.

Test Plan:
- Header W=3,H=2, 6 pixels (R=0..5), i_tready=1 constantly -> 6 beats R=0..5, o_tlast only on R=5, o_frame_done one pulse, o_width=3/o_height=2 throughout, back to IDLE.
- DEPTH_LOG2=2, W=8,H=1, i_tready=0 -> o_pix_rdy drops after 4 pushes; raise i_tready -> all 8 beats in order, tlast on the 8th, no overflow.
- Header W=0,H=5 -> o_hdr_rdy stays 1, no beats, no frame_done; next header W=1,H=1 with one pixel -> single beat with tlast=1.
- Random i_tready (50%) plus random i_pix_en, W=7,H=5 -> 35 beats, data in order, payload stable during stalls, tlast only on beat 35.
- i_pix_en pulsed in IDLE and i_hdr_en pulsed in STREAM -> o_overflow=1, pixel dropped, header ignored; the frame still completes with the original W/H.
- Assert rstn=0 after 3 of 6 pixels -> o_tvalid=0 immediately (async); after release the FIFO is empty, state IDLE, a new frame works correctly.

Source files
------------

// File: rtl/qoi_pixel_framer_if.sv
// qoi_pixel_framer_if: header, pixel and AXI-stream signals between decoder, framer and PPM sink
interface qoi_pixel_framer_if;
  logic        i_hdr_en;
  logic [31:0] i_width;
  logic [31:0] i_height;
  logic        o_hdr_rdy;
  logic        i_pix_en;
  logic [7:0]  i_R;
  logic [7:0]  i_G;
  logic [7:0]  i_B;
  logic        o_pix_rdy;
  logic        o_tvalid;
  logic        i_tready;
  logic        o_tlast;
  logic [7:0]  o_R;
  logic [7:0]  o_G;
  logic [7:0]  o_B;
  logic [31:0] o_width;
  logic [31:0] o_height;
  logic        o_frame_done;
  logic        o_overflow;
  modport slave (
    input  i_hdr_en, i_width, i_height, i_pix_en, i_R, i_G, i_B, i_tready,
    output o_hdr_rdy, o_pix_rdy, o_tvalid, o_tlast, o_R, o_G, o_B,
           o_width, o_height, o_frame_done, o_overflow
  );
  modport master (
    output i_hdr_en, i_width, i_height, i_pix_en, i_R, i_G, i_B, i_tready,
    input  o_hdr_rdy, o_pix_rdy, o_tvalid, o_tlast, o_R, o_G, o_B,
           o_width, o_height, o_frame_done, o_overflow
  );
endinterface

// File: rtl/qoi_pixel_framer.sv
// qoi_pixel_framer: latches QOI header, buffers RGB pixels in a FWFT FIFO, emits AXI-stream with end-of-image tlast
module qoi_pixel_framer #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic                 clk,
  input logic                 rstn,
  qoi_pixel_framer_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t              r_state;
  logic [31:0]         r_x, r_y, r_w, r_h;
  logic [DEPTH_LOG2:0] r_wr, r_rd;
  logic [24:0]         r_mem [DEPTH];
  logic                r_overflow;
  logic                w_full, w_empty, w_hdr, w_push, w_pop, w_xwrap, w_last;
  logic [24:0]         w_head;
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[DEPTH_LOG2] != r_rd[DEPTH_LOG2]) &&
                   (r_wr[DEPTH_LOG2-1:0] == r_rd[DEPTH_LOG2-1:0]);
  assign bus.o_hdr_rdy = r_state == IDLE;
  assign bus.o_pix_rdy = (r_state == STREAM) && !w_full;
  assign w_hdr   = bus.i_hdr_en && bus.o_hdr_rdy;
  assign w_push  = bus.i_pix_en && bus.o_pix_rdy;
  assign w_pop   = !w_empty && bus.i_tready;
  assign w_xwrap = r_x == r_w - 32'd1;
  assign w_last  = w_xwrap && (r_y == r_h - 32'd1);
  // Head is forced to zero when empty so outputs read as reset values under reset
  assign w_head  = w_empty ? '0 : r_mem[r_rd[DEPTH_LOG2-1:0]];
  assign {bus.o_tlast, bus.o_R, bus.o_G, bus.o_B} = w_head;
  assign bus.o_tvalid     = !w_empty;
  assign bus.o_frame_done = w_pop && w_head[24];
  assign bus.o_width      = r_w;
  assign bus.o_height     = r_h;
  assign bus.o_overflow   = r_overflow;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[DEPTH_LOG2-1:0]] <= {w_last, bus.i_R, bus.i_G, bus.i_B};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow || (bus.i_pix_en && !bus.o_pix_rdy);
      if (w_push) r_wr <= r_wr + (DEPTH_LOG2+1)'(1);
      if (w_pop) r_rd <= r_rd + (DEPTH_LOG2+1)'(1);
      case (r_state)
        IDLE:
          if (w_hdr) begin
            r_w     <= bus.i_width;
            r_h     <= bus.i_height;
            r_x     <= '0;
            r_y     <= '0;
            r_state <= (bus.i_width == '0 || bus.i_height == '0) ? IDLE : STREAM;
          end
        STREAM:
          if (w_push) begin
            r_x <= w_xwrap ? '0 : r_x + 32'd1;
            if (w_xwrap) r_y <= r_y + 32'd1;
            if (w_last) r_state <= DRAIN;
          end
        DRAIN:
          if (bus.o_frame_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
